// File: rtl/mem_stage_if.sv
// EXE->MEM request, data-memory bus and MEM->WB result bundle for mem_stage.
interface mem_stage_if #(
    parameter int DATA_W    = 32,
    parameter int MADDR_W   = 8,
    parameter int THROUGH_W = 11
) ();
    localparam int NB = DATA_W / 8;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_read;
    logic                 in_write;
    logic [1:0]           in_len;
    logic                 in_un;
    logic [THROUGH_W-1:0] in_through;
    logic [31:0]          in_addr;
    logic [DATA_W-1:0]    in_exe;

    logic                 mreq;
    logic [NB-1:0]        mwe;
    logic [MADDR_W-1:0]   maddr;
    logic [DATA_W-1:0]    mwdata;
    logic [DATA_W-1:0]    mrdata;
    logic                 mack;

    logic                 out_valid;
    logic                 out_ready;
    logic [THROUGH_W-1:0] out_through;
    logic [DATA_W-1:0]    out_result;
    logic                 out_misalign;

    modport slave (
        input  in_valid, in_read, in_write, in_len, in_un, in_through, in_addr, in_exe,
        input  mrdata, mack, out_ready,
        output in_ready, mreq, mwe, maddr, mwdata,
        output out_valid, out_through, out_result, out_misalign
    );

    modport master (
        output in_valid, in_read, in_write, in_len, in_un, in_through, in_addr, in_exe,
        output mrdata, mack, out_ready,
        input  in_ready, mreq, mwe, maddr, mwdata,
        input  out_valid, out_through, out_result, out_misalign
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues lane-aligned loads/stores with a req/ack
// handshake, extends loaded data, and forwards non-memory results to WB.
module mem_stage #(
    parameter int DATA_W    = 32,
    parameter int MADDR_W   = 8,
    parameter int THROUGH_W = 11
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;

    logic                 accept, take_ack, ready, valid;
    logic                 is_mem, misalign;
    logic [OB-1:0]        off;
    logic [7:0]           size_mask;
    logic [15:0]          mwe_wide;

    logic                 r_write, r_un;
    logic [1:0]           r_len;
    logic [OB-1:0]        r_off;
    logic [DATA_W-1:0]    r_exe;

    logic [DATA_W-1:0]    lane, keep, load_ext;
    logic                 fill;

    logic [NB-1:0]        mwe_q;
    logic [MADDR_W-1:0]   maddr_q;
    logic [DATA_W-1:0]    mwdata_q, result_q;
    logic [THROUGH_W-1:0] through_q;
    logic                 misalign_q;

    assign valid  = (state == DONE);
    assign ready  = (state == IDLE) & (~valid | bus.out_ready);
    assign is_mem = bus.in_read | bus.in_write;
    assign off    = bus.in_addr[OB-1:0];

    always_comb begin
        misalign  = 1'b0;
        size_mask = 8'h01;
        case (bus.in_len)
            2'b00: begin misalign = 1'b0;                                   size_mask = 8'h01; end
            2'b01: begin misalign = bus.in_addr[0];                         size_mask = 8'h03; end
            2'b10: begin misalign = |bus.in_addr[1:0];                      size_mask = 8'h0F; end
            default: begin misalign = (|bus.in_addr[2:0]) || (DATA_W == 32); size_mask = 8'hFF; end
        endcase
        misalign = misalign & is_mem;
    end

    assign mwe_wide = {8'h00, size_mask} << off;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        take_ack = 1'b0;
        case (state)
            IDLE: if (bus.in_valid && ready) begin
                accept   = 1'b1;
                state_nx = (is_mem && !misalign) ? REQ : DONE;
            end
            REQ: if (bus.mack) begin
                take_ack = 1'b1;
                state_nx = DONE;
            end
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane extraction: shift the addressed bytes down, then sign/zero fill above the access size.
    assign lane = bus.mrdata >> {r_off, 3'b000};

    always_comb begin
        keep = '1;
        fill = lane[DATA_W-1];
        case (r_len)
            2'b00:   begin keep = DATA_W'(8'hFF);         fill = lane[7];        end
            2'b01:   begin keep = DATA_W'(16'hFFFF);      fill = lane[15];       end
            2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); fill = lane[31];       end
            default: begin keep = '1;                     fill = lane[DATA_W-1]; end
        endcase
        load_ext = (lane & keep) | ({DATA_W{fill & ~r_un}} & ~keep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_un       <= 1'b0;
            r_len      <= '0;
            r_off      <= '0;
            r_exe      <= '0;
            mwe_q      <= '0;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            result_q   <= '0;
            through_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (accept) begin
                r_write   <= bus.in_write;
                r_un      <= bus.in_un;
                r_len     <= bus.in_len;
                r_off     <= off;
                r_exe     <= bus.in_exe;
                through_q <= bus.in_through;
                misalign_q <= misalign;
                if (is_mem && !misalign) begin
                    mwe_q    <= bus.in_write ? mwe_wide[NB-1:0] : '0;
                    maddr_q  <= bus.in_addr[OB+MADDR_W-1:OB];
                    mwdata_q <= bus.in_exe << {off, 3'b000};
                end else begin
                    result_q <= misalign ? DATA_W'(bus.in_addr) : bus.in_exe;
                end
            end
            if (take_ack) result_q <= r_write ? r_exe : load_ext;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.mreq         = (state == REQ);
    assign bus.mwe          = mwe_q;
    assign bus.maddr        = maddr_q;
    assign bus.mwdata       = mwdata_q;
    assign bus.out_valid    = valid;
    assign bus.out_through  = through_q;
    assign bus.out_result   = result_q;
    assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage at DATA_W=32 and DATA_W=64 against an arithmetic model.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(32), .MADDR_W(8), .THROUGH_W(11)) b32 ();
    mem_stage_if #(.DATA_W(64), .MADDR_W(8), .THROUGH_W(11)) b64 ();

    mem_stage #(.DATA_W(32), .MADDR_W(8), .THROUGH_W(11)) u32 (.clk(clk), .rst(rst), .bus(b32));
    mem_stage #(.DATA_W(64), .MADDR_W(8), .THROUGH_W(11)) u64 (.clk(clk), .rst(rst), .bus(b64));

    int checks = 0;
    int errors = 0;

    logic [1:0]  ov, mr, ir, ms;
    logic [63:0] res_v [2];
    logic [63:0] wd_v  [2];
    logic [7:0]  mwe_v [2];
    logic [7:0]  ma_v  [2];
    logic [10:0] thr_v [2];

    assign ov = {b64.out_valid, b32.out_valid};
    assign mr = {b64.mreq, b32.mreq};
    assign ir = {b64.in_ready, b32.in_ready};
    assign ms = {b64.out_misalign, b32.out_misalign};
    assign res_v[0] = 64'(b32.out_result);
    assign res_v[1] = b64.out_result;
    assign wd_v[0]  = 64'(b32.mwdata);
    assign wd_v[1]  = b64.mwdata;
    assign mwe_v[0] = 8'(b32.mwe);
    assign mwe_v[1] = b64.mwe;
    assign ma_v[0]  = b32.maddr;
    assign ma_v[1]  = b64.maddr;
    assign thr_v[0] = b32.out_through;
    assign thr_v[1] = b64.out_through;

    // Memory-side drive and per-operation expectations, one slot per DUT.
    logic        mack_v  [2];
    logic [63:0] mrd_v   [2];
    logic [63:0] rdata   [2];
    int          ack_wait[2];
    int          req_cyc [2];
    bit          auto_en [2];
    bit          active  [2];
    logic [63:0] exp_result[2];
    logic [63:0] exp_wd    [2];
    logic [7:0]  exp_mwe   [2];
    logic [7:0]  exp_ma    [2];
    logic [10:0] exp_thr   [2];
    bit          exp_mis   [2];
    bit          exp_iss   [2];
    logic [7:0]  cap_mwe   [2];
    logic [7:0]  cap_ma    [2];
    logic [63:0] cap_wd    [2];

    assign b32.mack   = mack_v[0];
    assign b32.mrdata = mrd_v[0][31:0];
    assign b64.mack   = mack_v[1];
    assign b64.mrdata = mrd_v[1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Outcome of one instruction computed from the access rules with plain arithmetic.
    function automatic void model(input int dw, input bit rd, input bit wr, input int len, input bit un,
                                  input logic [31:0] addr, input logic [63:0] exe, input logic [63:0] rdat,
                                  output bit mis, output bit iss, output logic [63:0] res,
                                  output logic [7:0] we, output logic [7:0] ma, output logic [63:0] wd);
        int nb, bytes, off, a;
        logic [63:0] dmask, lmask, v;
        nb    = dw / 8;
        bytes = 1 << len;
        a     = int'(addr[15:0]);
        off   = a % nb;
        dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        lmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        mis   = (rd || wr) && (((a % bytes) != 0) || (bytes > nb));
        iss   = (rd || wr) && !mis;
        we    = (iss && wr) ? 8'(((1 << bytes) - 1) << off) : 8'h00;
        ma    = 8'(a / nb);
        wd    = (exe << (8 * off)) & dmask;
        if (!(rd || wr))  res = exe & dmask;
        else if (mis)     res = {32'h0, addr};
        else if (wr)      res = exe & dmask;
        else begin
            v = (rdat >> (8 * off)) & lmask;
            if (!un && v[8 * bytes - 1]) v = v | ~lmask;
            res = v & dmask;
        end
    endfunction

    task automatic drive(input int d, input bit vld, input bit rd, input bit wr, input int len, input bit un,
                         input logic [31:0] addr, input logic [63:0] exe, input logic [10:0] thr);
        if (d == 0) begin
            b32.in_valid = vld; b32.in_read = rd; b32.in_write = wr; b32.in_len = 2'(len);
            b32.in_un = un; b32.in_addr = addr; b32.in_exe = exe[31:0]; b32.in_through = thr;
        end else begin
            b64.in_valid = vld; b64.in_read = rd; b64.in_write = wr; b64.in_len = 2'(len);
            b64.in_un = un; b64.in_addr = addr; b64.in_exe = exe; b64.in_through = thr;
        end
    endtask

    task automatic set_ready(input int d, input bit r);
        if (d == 0) b32.out_ready = r;
        else        b64.out_ready = r;
    endtask

    task automatic do_op(input int d, input bit rd, input bit wr, input int len, input bit un,
                         input logic [31:0] addr, input logic [63:0] exe, input logic [10:0] thr,
                         input logic [63:0] rdat, input int ackd, input int stall, input logic [63:0] lit);
        bit mis, iss;
        logic [63:0] res, wd;
        logic [7:0] we, ma;
        int lat;
        model(d ? 64 : 32, rd, wr, len, un, addr, exe, rdat, mis, iss, res, we, ma, wd);
        exp_result[d] = res; exp_mis[d] = mis; exp_iss[d] = iss;
        exp_mwe[d] = we; exp_ma[d] = ma; exp_wd[d] = wd; exp_thr[d] = thr;
        rdata[d] = rdat; ack_wait[d] = ackd; req_cyc[d] = 0;
        @(negedge clk);
        chk($sformatf("in_ready_idle[%0d]", d), 64'(ir[d]), 64'd1);
        active[d] = 1'b1;
        drive(d, 1'b1, rd, wr, len, un, addr, exe, thr);
        set_ready(d, stall == 0);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 64'h0, 11'h0);
        lat = 1;
        while (!ov[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("out_valid_seen[%0d]", d), 64'(ov[d]), 64'd1);
        chk($sformatf("latency[%0d]", d), 64'(lat), iss ? 64'(ackd + 1) : 64'd1);
        chk($sformatf("mreq_cycles[%0d]", d), 64'(req_cyc[d]), iss ? 64'(ackd) : 64'd0);
        chk($sformatf("literal_result[%0d]", d), res_v[d], lit);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            set_ready(d, 1'b1);
        end
        @(posedge clk); #1;
        chk($sformatf("out_valid_drop[%0d]", d), 64'(ov[d]), 64'd0);
        active[d] = 1'b0;
    endtask

    // Auto-responding memory: acks in the ack_wait-th request cycle, returns junk otherwise.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (auto_en[d]) begin
                    if (mr[d] && !rst) begin
                        req_cyc[d]++;
                        if (req_cyc[d] == ack_wait[d]) begin
                            mack_v[d] = 1'b1;
                            mrd_v[d]  = rdata[d];
                            cap_mwe[d] = mwe_v[d];
                            cap_ma[d]  = ma_v[d];
                            cap_wd[d]  = wd_v[d];
                        end else begin
                            mack_v[d] = 1'b0;
                            mrd_v[d]  = ~rdata[d];
                        end
                    end else begin
                        mack_v[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the current expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (active[d]) begin
                    if (ov[d]) begin
                        chk($sformatf("out_result[%0d]", d), res_v[d], exp_result[d]);
                        chk($sformatf("out_misalign[%0d]", d), 64'(ms[d]), 64'(exp_mis[d]));
                        chk($sformatf("out_through[%0d]", d), 64'(thr_v[d]), 64'(exp_thr[d]));
                        chk($sformatf("in_ready_done[%0d]", d), 64'(ir[d]), 64'd0);
                    end
                    if (mr[d]) begin
                        chk($sformatf("mreq_allowed[%0d]", d), 64'(mr[d]), 64'(exp_iss[d]));
                        chk($sformatf("mwe[%0d]", d), 64'(mwe_v[d]), 64'(exp_mwe[d]));
                        chk($sformatf("maddr[%0d]", d), 64'(ma_v[d]), 64'(exp_ma[d]));
                        chk($sformatf("mwdata[%0d]", d), wd_v[d], exp_wd[d]);
                    end
                end else begin
                    chk($sformatf("idle_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
                    chk($sformatf("idle_mreq[%0d]", d), 64'(mr[d]), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mack_v[d] = 1'b0; mrd_v[d] = '0; auto_en[d] = 1'b1; active[d] = 1'b0;
            drive(d, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 64'h0, 11'h0);
            set_ready(d, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_out_valid[%0d]", d), 64'(ov[d]), 64'd0);
            chk($sformatf("rst_mreq[%0d]", d), 64'(mr[d]), 64'd0);
            chk($sformatf("rst_mwe[%0d]", d), 64'(mwe_v[d]), 64'd0);
            chk($sformatf("rst_maddr[%0d]", d), 64'(ma_v[d]), 64'd0);
            chk($sformatf("rst_mwdata[%0d]", d), wd_v[d], 64'd0);
            chk($sformatf("rst_result[%0d]", d), res_v[d], 64'd0);
            chk($sformatf("rst_through[%0d]", d), 64'(thr_v[d]), 64'd0);
            chk($sformatf("rst_misalign[%0d]", d), 64'(ms[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        //     d rd wr len un addr         exe                    thr     mrdata                 ack stall literal
        do_op(0, 0, 0, 2, 0, 32'h0000_0000, 64'h1234_5678,          11'h155, 64'h0,                 0, 0, 64'h1234_5678);
        do_op(0, 0, 1, 0, 0, 32'h0000_0007, 64'hAB,                 11'h02A, 64'h0,                 3, 0, 64'hAB);
        chk("store_byte_mwe",    64'(cap_mwe[0]), 64'h8);
        chk("store_byte_maddr",  64'(cap_ma[0]),  64'h1);
        chk("store_byte_mwdata", cap_wd[0],       64'hAB00_0000);
        do_op(0, 1, 0, 1, 0, 32'h0000_0002, 64'h0,                  11'h7FF, 64'h8001_FFFF,         1, 0, 64'hFFFF_8001);
        do_op(0, 1, 0, 1, 1, 32'h0000_0002, 64'h0,                  11'h001, 64'h8001_FFFF,         2, 0, 64'h0000_8001);
        do_op(0, 1, 0, 2, 0, 32'h0000_0006, 64'h55,                 11'h0F0, 64'h0,                 1, 0, 64'h6);
        do_op(0, 1, 1, 2, 0, 32'h0000_0104, 64'hDEAD_BEEF,          11'h333, 64'h0,                 1, 0, 64'hDEAD_BEEF);
        do_op(0, 1, 0, 3, 0, 32'h0000_0008, 64'h0,                  11'h444, 64'h0,                 1, 0, 64'h8);
        do_op(0, 1, 0, 0, 1, 32'h0000_0003, 64'h0,                  11'h123, 64'h80FF_FFFF,         1, 2, 64'h80);
        do_op(1, 1, 0, 3, 0, 32'h0000_0008, 64'h0,                  11'h3C3, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0123_4567_89AB_CDEF);
        chk("dword_mwe", 64'(cap_mwe[1]), 64'h0);
        do_op(1, 1, 0, 0, 0, 32'h0000_000F, 64'h0,                  11'h0AA, 64'h8000_0000_0000_0000, 2, 0, 64'hFFFF_FFFF_FFFF_FF80);
        do_op(1, 1, 0, 2, 0, 32'h0000_0004, 64'h0,                  11'h555, 64'h8765_4321_0000_0000, 1, 0, 64'hFFFF_FFFF_8765_4321);
        do_op(1, 0, 1, 1, 0, 32'h0000_0012, 64'hBEEF,               11'h00F, 64'h0,                 2, 0, 64'hBEEF);
        do_op(1, 0, 0, 0, 0, 32'h0000_0000, 64'hCAFE_F00D_1234_5678, 11'h70E, 64'h0,                 0, 5, 64'hCAFE_F00D_1234_5678);

        // Reset while a request is outstanding; a late ack must not produce a result.
        begin
            bit mis, iss;
            logic [63:0] res, wd;
            logic [7:0] we, ma;
            model(32, 1'b1, 1'b0, 2, 1'b0, 32'h20, 64'h0, 64'h0, mis, iss, res, we, ma, wd);
            exp_result[0] = res; exp_mis[0] = mis; exp_iss[0] = iss;
            exp_mwe[0] = we; exp_ma[0] = ma; exp_wd[0] = wd; exp_thr[0] = 11'h011;
            auto_en[0] = 1'b0;
            mack_v[0] = 1'b0;
            @(negedge clk);
            active[0] = 1'b1;
            drive(0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 32'h20, 64'h0, 11'h011);
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0, 64'h0, 11'h0);
            chk("rst_test_mreq_up", 64'(mr[0]), 64'd1);
            chk("rst_test_maddr", 64'(ma_v[0]), 64'h08);
            @(negedge clk);
            rst = 1'b1;
            active[0] = 1'b0;
            @(posedge clk); #1;
            chk("rst_drops_mreq", 64'(mr[0]), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            mack_v[0] = 1'b1;
            mrd_v[0] = 64'h1111_1111;
            @(negedge clk);
            mack_v[0] = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                chk("late_mack_out_valid", 64'(ov[0]), 64'd0);
                chk("late_mack_in_ready", 64'(ir[0]), 64'd1);
            end
            auto_en[0] = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
